// File: rtl/ahb_lite_fill_master.sv
// rtl/ahb_lite_fill_master.sv - AHB-Lite initiator filling consecutive words with a constant or incrementing value
module ahb_lite_fill_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic [31:0] cmd_data,
    input  logic        cmd_incr,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        beat_adv;
    logic        finish_ok;
    logic        finish_err;
    logic [31:0] addr_q;
    logic [15:0] remaining;
    logic [15:0] beat_idx;
    logic [31:0] fill_q;
    logic        incr_q;
    logic [31:0] hwdata_q;
    logic        done_q;
    logic        err_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^cmd_addr[1:0];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An ERROR response in ADDR belongs to the previous beat's data phase;
    // the address currently on the bus is dropped, never retried.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        beat_adv   = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_len != 16'd0) begin
                        state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (HRESP) begin
                    if (HREADY) begin
                        finish_err = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end else if (HREADY) begin
                    beat_adv = 1'b1;
                    if (remaining == 16'd1) begin
                        state_nxt = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (HRESP) begin
                    if (HREADY) begin
                        finish_err = 1'b1;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end else if (HREADY) begin
                    finish_ok = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    finish_err = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q    <= 32'd0;
            remaining <= 16'd0;
            beat_idx  <= 16'd0;
            fill_q    <= 32'd0;
            incr_q    <= 1'b0;
            hwdata_q  <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                addr_q    <= {cmd_addr[31:2], 2'b00};
                remaining <= cmd_len;
                beat_idx  <= 16'd0;
                fill_q    <= cmd_data;
                incr_q    <= cmd_incr;
                err_q     <= 1'b0;
                if (cmd_len == 16'd0) begin
                    done_q <= 1'b1;
                end
            end
            // Write data is captured as the address phase completes, so it is
            // present from the first data-phase cycle and frozen across stalls.
            if (beat_adv) begin
                addr_q    <= addr_q + 32'd4;
                remaining <= remaining - 16'd1;
                beat_idx  <= beat_idx + 16'd1;
                hwdata_q  <= fill_q + (incr_q ? {16'd0, beat_idx} : 32'd0);
            end
            if (finish_ok) begin
                done_q <= 1'b1;
            end
            if (finish_err) begin
                done_q <= 1'b1;
                err_q  <= 1'b1;
            end
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state != S_IDLE) || done_q;
    assign HADDR     = addr_q;
    assign HTRANS    = (state == S_ADDR) ? 2'b10 : 2'b00;
    assign HWRITE    = (state == S_ADDR);
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_fill_master.sv
// tb/tb_ahb_lite_fill_master.sv - scoreboard bench for ahb_lite_fill_master with a reactive slave model
module tb_ahb_lite_fill_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = 32'd0;
    logic [15:0] cmd_len = 16'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_incr = 1'b0;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    ahb_lite_fill_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_data(cmd_data), .cmd_incr(cmd_incr),
        .done(done), .err(err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_done_cyc[$];
    bit          exp_done_err[$];
    int          sl_wait[$];
    bit          sl_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Monitor and slave model: checks bus/completion events, then decides next-cycle HREADY/HRESP
    bit dp_active = 1'b0;
    bit new_dp;
    int w_left = 0;
    bit e_flag = 1'b0;
    int e_stage = 0;
    int nw;
    bit ne;
    bit prev_err1 = 1'b0;
    bit nxt_rdy = 1'b1;
    bit nxt_resp = 1'b0;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp_active = 1'b0;
            prev_err1 = 1'b0;
            nxt_rdy   = 1'b1;
            nxt_resp  = 1'b0;
        end else begin
            new_dp = 1'b0;
            chk("hwrite", 32'(HWRITE), 32'(HTRANS == 2'b10));
            if (prev_err1) chk("htrans_2nd_err_cycle", 32'(HTRANS), 32'd0);
            prev_err1 = HRESP && !HREADY;
            if (dp_active) begin
                if (exp_data.size() == 0) bad("unexpected_data_phase", HWDATA);
                else begin
                    chk("hwdata", HWDATA, exp_data[0]);
                    if (HREADY) void'(exp_data.pop_front());
                end
            end
            if (HTRANS == 2'b10 && HREADY) begin
                if (exp_addr.size() == 0) bad("unexpected_nonseq", HADDR);
                else chk("haddr", HADDR, exp_addr.pop_front());
                new_dp = 1'b1;
                nw = (sl_wait.size() != 0) ? sl_wait.pop_front() : 0;
                ne = (sl_err.size() != 0) ? sl_err.pop_front() : 1'b0;
            end
            if (done) begin
                if (exp_done_cyc.size() == 0) bad("unexpected_done", 32'(err));
                else begin
                    chk("done_cycle", 32'(cyc), 32'(exp_done_cyc.pop_front()));
                    chk("err_with_done", 32'(err), 32'(exp_done_err.pop_front()));
                    chk("busy_at_done", 32'(busy), 32'd1);
                    chk("ready_at_done", 32'(cmd_ready), 32'd1);
                end
            end
            if (new_dp) begin
                dp_active = 1'b1;
                w_left    = nw;
                e_flag    = ne;
                e_stage   = 0;
            end else if (HREADY) begin
                dp_active = 1'b0;
            end
            nxt_rdy  = 1'b1;
            nxt_resp = 1'b0;
            if (dp_active) begin
                if (e_flag) begin
                    nxt_rdy  = (e_stage != 0);
                    nxt_resp = 1'b1;
                    e_stage++;
                end else if (w_left > 0) begin
                    nxt_rdy = 1'b0;
                    w_left--;
                end
            end
        end
    end

    always @(posedge HCLK) begin
        #1;
        HREADY = nxt_rdy;
        HRESP  = nxt_resp;
    end

    task automatic beat(input logic [31:0] a, input logic [31:0] d, input int w, input bit e);
        exp_addr.push_back(a);
        exp_data.push_back(d);
        sl_wait.push_back(w);
        sl_err.push_back(e);
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic [15:0] len, input logic [31:0] d,
                             input logic inc, input int done_off, input bit e);
        int n;
        n = 0;
        @(posedge HCLK); #1;
        while (!cmd_ready && n < 200) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (n >= 200) bad("cmd_ready_timeout", 32'(cmd_ready));
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_data  = d;
        cmd_incr  = inc;
        exp_done_cyc.push_back(cyc + done_off);
        exp_done_err.push_back(e);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while (exp_done_cyc.size() != 0 && n < 200) begin
            @(posedge HCLK);
            n++;
        end
        if (n >= 200) bad("done_timeout", 32'(exp_done_cyc.size()));
        @(posedge HCLK); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
        chk({tag, "_haddr"}, HADDR, 32'd0);
        chk({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
        chk({tag, "_hwdata"}, HWDATA, 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        check_reset_outputs("rst");
        chk("hsize", 32'(HSIZE), 32'd2);
        chk("hburst", 32'(HBURST), 32'd0);
        chk("hprot", 32'(HPROT), 32'd3);
        chk("hmastlock", 32'(HMASTLOCK), 32'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // zero-wait constant fill
        beat(32'h2000_0000, 32'hA5A5_A5A5, 0, 0);
        beat(32'h2000_0004, 32'hA5A5_A5A5, 0, 0);
        beat(32'h2000_0008, 32'hA5A5_A5A5, 0, 0);
        beat(32'h2000_000C, 32'hA5A5_A5A5, 0, 0);
        issue_cmd(32'h2000_0000, 16'd4, 32'hA5A5_A5A5, 1'b0, 6, 1'b0);
        wait_quiet();

        // incrementing fill wrapping the data value, two wait states on beat 1
        beat(32'h1000_0010, 32'hFFFF_FFFE, 0, 0);
        beat(32'h1000_0014, 32'hFFFF_FFFF, 2, 0);
        beat(32'h1000_0018, 32'h0000_0000, 0, 0);
        issue_cmd(32'h1000_0010, 16'd3, 32'hFFFF_FFFE, 1'b1, 7, 1'b0);
        wait_quiet();

        // zero length
        issue_cmd(32'h3000_0000, 16'd0, 32'h1111_2222, 1'b0, 1, 1'b0);
        wait_quiet();

        // address wrap with misaligned low bits
        beat(32'hFFFF_FFF8, 32'h1234_5678, 0, 0);
        beat(32'hFFFF_FFFC, 32'h1234_5679, 0, 0);
        beat(32'h0000_0000, 32'h1234_567A, 0, 0);
        issue_cmd(32'hFFFF_FFFB, 16'd3, 32'h1234_5678, 1'b1, 5, 1'b0);
        wait_quiet();

        // ERROR on beat 2 data phase; beats 3 and 4 never accepted
        beat(32'h4000_0000, 32'hDEAD_BEEF, 0, 0);
        beat(32'h4000_0004, 32'hDEAD_BEEF, 0, 0);
        beat(32'h4000_0008, 32'hDEAD_BEEF, 0, 1);
        issue_cmd(32'h4000_0000, 16'd5, 32'hDEAD_BEEF, 1'b0, 6, 1'b1);
        wait_quiet();
        chk("err_held", 32'(err), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);

        // recovery, then a back-to-back command accepted in the done cycle
        beat(32'h5000_0100, 32'h0000_0001, 0, 0);
        beat(32'h5000_0104, 32'h0000_0002, 0, 0);
        beat(32'h6000_0000, 32'h0000_0077, 0, 0);
        issue_cmd(32'h5000_0100, 16'd2, 32'h0000_0001, 1'b1, 4, 1'b0);
        issue_cmd(32'h6000_0000, 16'd1, 32'h0000_0077, 1'b0, 3, 1'b0);
        wait_quiet();
        chk("err_cleared", 32'(err), 32'd0);

        // reset during beat 2 address phase
        for (int k = 0; k < 6; k++) beat(32'h7000_0000 + 32'(4 * k), 32'h1111_1111, 0, 0);
        issue_cmd(32'h7000_0000, 16'd6, 32'h1111_1111, 1'b0, 8, 1'b0);
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_addr.delete();
        exp_data.delete();
        sl_wait.delete();
        sl_err.delete();
        exp_done_cyc.delete();
        exp_done_err.delete();
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        repeat (10) @(posedge HCLK);
        #1;

        beat(32'h8000_0000, 32'hCAFE_F00D, 0, 0);
        beat(32'h8000_0004, 32'hCAFE_F00D, 0, 0);
        issue_cmd(32'h8000_0000, 16'd2, 32'hCAFE_F00D, 1'b0, 4, 1'b0);
        wait_quiet();

        chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
        chk("data_queue_drained", 32'(exp_data.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
